// File: rtl/dmem_pkg.sv
// Shared types, constants and address checking for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned WAIT_CNT_W     = 4;

    // Flags a word access that is misaligned or lands beyond the last RAM word.
    function automatic logic addr_err(input logic [31:0] addr, input int unsigned entry_count);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= entry_count);
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM: byte-enable synchronous write, asynchronous read, synchronous clear.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned ENTRY_COUNT = 32
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           we,
    input  logic [$clog2(ENTRY_COUNT)-1:0] idx,
    input  logic [BIT_WIDTH-1:0]           wdata,
    input  logic [BYTES_PER_WORD-1:0]      be,
    output logic [BIT_WIDTH-1:0]           rdata
);

    logic [BIT_WIDTH-1:0] mem [ENTRY_COUNT];

    // Clear every word on reset, otherwise merge the enabled byte lanes into the indexed word.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < ENTRY_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            for (int unsigned b = 0; b < BYTES_PER_WORD; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one outstanding load/store, programmable wait states, error reporting.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int unsigned BIT_WIDTH   = 32,
    parameter int unsigned ENTRY_COUNT = 32,
    parameter int unsigned LATENCY     = 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [31:0]               req_addr,
    input  logic [BIT_WIDTH-1:0]      req_wdata,
    input  logic [BYTES_PER_WORD-1:0] req_be,
    output logic                      rsp_valid,
    input  logic                      rsp_ready,
    output logic [BIT_WIDTH-1:0]      rsp_rdata,
    output logic                      rsp_err
);

    localparam int unsigned IDX_W = $clog2(ENTRY_COUNT);
    localparam logic [WAIT_CNT_W-1:0] CNT_LOAD =
        (LATENCY > 0) ? WAIT_CNT_W'(LATENCY - 1) : '0;

    state_t                    state, state_nxt;
    logic [WAIT_CNT_W-1:0]     cnt, cnt_nxt;
    logic                      accept, commit;

    logic                      lat_we;
    logic [31:0]               lat_addr;
    logic [BIT_WIDTH-1:0]      lat_wdata;
    logic [BYTES_PER_WORD-1:0] lat_be;

    logic                      acc_we;
    logic [31:0]               acc_addr;
    logic [BIT_WIDTH-1:0]      acc_wdata;
    logic [BYTES_PER_WORD-1:0] acc_be;
    logic                      acc_err;
    logic [IDX_W-1:0]          acc_idx;
    logic [BIT_WIDTH-1:0]      arr_rdata;

    // State and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state logic; also decides when a request is accepted and when the access commits.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        accept    = 1'b0;
        commit    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (LATENCY == 0) begin
                        commit    = 1'b1;
                        state_nxt = RESP;
                    end else begin
                        cnt_nxt   = CNT_LOAD;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - WAIT_CNT_W'(1);
                end else begin
                    commit    = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Capture the request fields at the accept edge; they drive the commit after wait states.
    always_ff @(posedge clk) begin
        if (rst) begin
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
        end else if (accept) begin
            lat_we    <= req_we;
            lat_addr  <= req_addr;
            lat_wdata <= req_wdata;
            lat_be    <= req_be;
        end
    end

    // With zero wait states the commit happens on the accept edge, so the live request is used then.
    always_comb begin
        if (state == IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end else begin
            acc_we    = lat_we;
            acc_addr  = lat_addr;
            acc_wdata = lat_wdata;
            acc_be    = lat_be;
        end
        acc_err = addr_err(acc_addr, ENTRY_COUNT);
        acc_idx = acc_addr[IDX_W+1:2];
    end

    dmem_array #(
        .BIT_WIDTH  (BIT_WIDTH),
        .ENTRY_COUNT(ENTRY_COUNT)
    ) u_array (
        .clk  (clk),
        .rst  (rst),
        .we   (commit && acc_we && !acc_err),
        .idx  (acc_idx),
        .wdata(acc_wdata),
        .be   (acc_be),
        .rdata(arr_rdata)
    );

    // Response registers: loaded at commit, held through backpressure, cleared on handshake.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_valid <= 1'b1;
            rsp_err   <= acc_err;
            rsp_rdata <= (acc_err || acc_we) ? '0 : arr_rdata;
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end
    end

    assign req_ready = (state == IDLE) && !rst;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: three responders (LATENCY 1, 0, 3) against a transaction-level model.
module tb_dmem_responder;

    logic        clk = 1'b0;
    logic [2:0]  rst_v;
    logic [2:0]  req_valid_v, req_we_v, rsp_ready_v;
    logic [2:0]  req_ready_v, rsp_valid_v, rsp_err_v;
    logic [31:0] req_addr_a [3];
    logic [31:0] req_wdata_a[3];
    logic [3:0]  req_be_a   [3];
    logic [31:0] rsp_rdata_a[3];

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_responder #(
            .BIT_WIDTH  (32),
            .ENTRY_COUNT(32),
            .LATENCY    (g == 0 ? 1 : (g == 1 ? 0 : 3))
        ) u_dut (
            .clk      (clk),
            .rst      (rst_v[g]),
            .req_valid(req_valid_v[g]),
            .req_ready(req_ready_v[g]),
            .req_we   (req_we_v[g]),
            .req_addr (req_addr_a[g]),
            .req_wdata(req_wdata_a[g]),
            .req_be   (req_be_a[g]),
            .rsp_valid(rsp_valid_v[g]),
            .rsp_ready(rsp_ready_v[g]),
            .rsp_rdata(rsp_rdata_a[g]),
            .rsp_err  (rsp_err_v[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 0 : 3);
    endfunction

    function automatic bit ref_err(input logic [31:0] a);
        return ((a % 4) != 0) || ((a / 4) >= 32);
    endfunction

    function automatic logic [31:0] lane_mask(input logic [3:0] be);
        return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    endfunction

    function automatic void chk(input string name, input int k,
                                input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            $display("FAIL %s[dut%0d] got=%h expected=%h t=%0t", name, k, act, exp, $time);
        end else begin
            n_pass++;
        end
    endfunction

    // Transaction-level reference: memory image, one outstanding request, age since accept.
    bit [31:0] m_mem  [3][32];
    bit        m_busy [3];
    int        m_age  [3];
    bit [31:0] m_rdata[3];
    bit        m_err  [3];
    bit        m_ok = 1'b0;

    always @(posedge clk) begin
        if (rst_v == 3'b111) m_ok <= 1'b1;
        for (int k = 0; k < 3; k++) begin
            if (rst_v[k]) begin
                m_busy[k]  <= 1'b0;
                m_age[k]   <= 0;
                m_rdata[k] <= '0;
                m_err[k]   <= 1'b0;
                for (int i = 0; i < 32; i++) m_mem[k][i] <= '0;
            end else if (!m_busy[k]) begin
                if (req_valid_v[k]) begin
                    m_busy[k]  <= 1'b1;
                    m_age[k]   <= 0;
                    m_err[k]   <= ref_err(req_addr_a[k]);
                    m_rdata[k] <= (ref_err(req_addr_a[k]) || req_we_v[k]) ? 32'h0
                                  : m_mem[k][(req_addr_a[k] / 4) % 32];
                    if (!ref_err(req_addr_a[k]) && req_we_v[k])
                        m_mem[k][(req_addr_a[k] / 4) % 32] <=
                            (m_mem[k][(req_addr_a[k] / 4) % 32] & ~lane_mask(req_be_a[k])) |
                            (req_wdata_a[k] & lane_mask(req_be_a[k]));
                end
            end else if (m_age[k] >= lat_of(k) && rsp_ready_v[k]) begin
                m_busy[k] <= 1'b0;
            end else begin
                m_age[k] <= m_age[k] + 1;
            end
        end
    end

    // Every cycle, compare all DUT outputs with the model's view.
    always @(negedge clk) begin
        if (m_ok) begin
            for (int k = 0; k < 3; k++) begin
                chk("req_ready", k, 32'(req_ready_v[k]), 32'(!m_busy[k] && !rst_v[k]));
                chk("rsp_valid", k, 32'(rsp_valid_v[k]), 32'(m_busy[k] && m_age[k] >= lat_of(k)));
                chk("rsp_rdata", k, rsp_rdata_a[k],
                    (m_busy[k] && m_age[k] >= lat_of(k)) ? m_rdata[k] : 32'h0);
                chk("rsp_err", k, 32'(rsp_err_v[k]),
                    32'(m_busy[k] && m_age[k] >= lat_of(k) && m_err[k]));
            end
        end
    end

    // Hold req_valid until an edge where req_ready was high; returns just after that accept edge.
    task automatic do_accept(input int k, output bit ok);
        int n = 0;
        ok = 1'b0;
        while (!ok && n < 50) begin
            @(negedge clk);
            ok = req_ready_v[k];
            n++;
            @(posedge clk);
        end
    endtask

    // One full transaction; cyc = cycles from accept edge to first rsp_valid cycle.
    task automatic txn(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wd, input logic [3:0] be,
                       output logic [31:0] rd, output logic er, output int cyc);
        bit ok;
        bit got = 1'b0;
        req_we_v[k]    = we;
        req_addr_a[k]  = addr;
        req_wdata_a[k] = wd;
        req_be_a[k]    = be;
        rsp_ready_v[k] = 1'b1;
        req_valid_v[k] = 1'b1;
        rd  = '0;
        er  = 1'b0;
        cyc = 1;
        do_accept(k, ok);
        #1 req_valid_v[k] = 1'b0;
        if (!ok) begin
            chk("accept_timeout", k, 32'(ok), 32'd1);
            return;
        end
        while (!got && cyc < 50) begin
            @(negedge clk);
            if (rsp_valid_v[k]) got = 1'b1;
            else cyc++;
        end
        if (!got) begin
            chk("rsp_timeout", k, 32'(got), 32'd1);
            return;
        end
        rd = rsp_rdata_a[k];
        er = rsp_err_v[k];
        @(posedge clk);
        #2;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got=timeout expected=finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] rd;
        logic        er;
        int          cyc;
        int          n;
        bit          ok;

        rst_v       = 3'b111;
        req_valid_v = '0;
        req_we_v    = '0;
        rsp_ready_v = 3'b111;
        for (int k = 0; k < 3; k++) begin
            req_addr_a[k]  = '0;
            req_wdata_a[k] = '0;
            req_be_a[k]    = '0;
        end

        // Reset state.
        @(negedge clk);
        chk("rst_req_ready", 0, 32'(req_ready_v), 32'd0);
        chk("rst_rsp_valid", 0, 32'(rsp_valid_v), 32'd0);
        @(posedge clk);
        #2 rst_v = '0;
        @(negedge clk);
        chk("idle_req_ready", 0, 32'(req_ready_v), 32'h7);

        // Store then load back, LATENCY=1.
        txn(0, 1'b1, 32'h08, 32'hDEADBEEF, 4'hF, rd, er, cyc);
        chk("st_cyc", 0, cyc, 32'd2);
        chk("st_rdata", 0, rd, 32'h0);
        chk("st_err", 0, 32'(er), 32'd0);
        txn(0, 1'b0, 32'h08, 32'h0, 4'h0, rd, er, cyc);
        chk("ld_rdata", 0, rd, 32'hDEADBEEF);

        // Byte-enable merge.
        txn(0, 1'b1, 32'h04, 32'h11223344, 4'hF, rd, er, cyc);
        txn(0, 1'b1, 32'h04, 32'hAABBCCDD, 4'b0101, rd, er, cyc);
        txn(0, 1'b0, 32'h04, 32'h0, 4'h0, rd, er, cyc);
        chk("merge_rdata", 0, rd, 32'h11BB33DD);

        // Misaligned load and out-of-range store.
        txn(0, 1'b0, 32'h06, 32'h0, 4'h0, rd, er, cyc);
        chk("misalign_err", 0, 32'(er), 32'd1);
        chk("misalign_rdata", 0, rd, 32'h0);
        txn(0, 1'b1, 32'h80, 32'hFFFFFFFF, 4'hF, rd, er, cyc);
        chk("oor_err", 0, 32'(er), 32'd1);

        // Empty byte-enable store is a normal no-op.
        txn(0, 1'b1, 32'h08, 32'h12345678, 4'h0, rd, er, cyc);
        chk("be0_err", 0, 32'(er), 32'd0);

        for (int w = 0; w < 32; w++) begin
            txn(0, 1'b0, 32'(w * 4), 32'h0, 4'h0, rd, er, cyc);
            chk("readback", w, rd, (w == 1) ? 32'h11BB33DD : ((w == 2) ? 32'hDEADBEEF : 32'h0));
        end

        // Backpressure with a competing request held during RESP.
        req_we_v[0]    = 1'b0;
        req_addr_a[0]  = 32'h08;
        rsp_ready_v[0] = 1'b0;
        req_valid_v[0] = 1'b1;
        do_accept(0, ok);
        chk("bp_accept", 0, 32'(ok), 32'd1);
        #1 req_addr_a[0] = 32'h04;
        n = 0;
        while (!rsp_valid_v[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_rise", 0, 32'(rsp_valid_v[0]), 32'd1);
        for (int i = 0; i < 5; i++) begin
            if (i > 0) @(negedge clk);
            chk("bp_valid", 0, 32'(rsp_valid_v[0]), 32'd1);
            chk("bp_rdata", 0, rsp_rdata_a[0], 32'hDEADBEEF);
            chk("bp_req_ready", 0, 32'(req_ready_v[0]), 32'd0);
        end
        @(posedge clk);
        #2 rsp_ready_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_idle_ready", 0, 32'(req_ready_v[0]), 32'd1);
        chk("bp_idle_valid", 0, 32'(rsp_valid_v[0]), 32'd0);
        @(posedge clk);
        #2 req_valid_v[0] = 1'b0;
        @(negedge clk);
        chk("bp_second_taken", 0, 32'(req_ready_v[0]), 32'd0);
        n = 0;
        while (!rsp_valid_v[0] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("bp_second_rdata", 0, rsp_rdata_a[0], 32'h11BB33DD);
        @(posedge clk);
        #2;

        // LATENCY=0 timing.
        txn(1, 1'b1, 32'h10, 32'hCAFEF00D, 4'hF, rd, er, cyc);
        chk("l0_cyc", 1, cyc, 32'd1);
        txn(1, 1'b0, 32'h10, 32'h0, 4'h0, rd, er, cyc);
        chk("l0_rdata", 1, rd, 32'hCAFEF00D);

        // LATENCY=3 timing.
        txn(2, 1'b1, 32'h14, 32'h0BADF00D, 4'hF, rd, er, cyc);
        chk("l3_cyc", 2, cyc, 32'd4);
        txn(2, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, cyc);
        chk("l3_rdata", 2, rd, 32'h0BADF00D);
        chk("l3_ld_cyc", 2, cyc, 32'd4);

        // Reset during WAIT discards the pending store.
        req_we_v[2]    = 1'b1;
        req_addr_a[2]  = 32'h0C;
        req_wdata_a[2] = 32'h12345678;
        req_be_a[2]    = 4'hF;
        req_valid_v[2] = 1'b1;
        do_accept(2, ok);
        chk("mid_accept", 2, 32'(ok), 32'd1);
        #2 req_valid_v[2] = 1'b0;
        @(posedge clk);
        #2 rst_v[2] = 1'b1;
        @(posedge clk);
        #2 rst_v[2] = 1'b0;
        @(negedge clk);
        chk("mid_rsp_valid", 2, 32'(rsp_valid_v[2]), 32'd0);
        chk("mid_req_ready", 2, 32'(req_ready_v[2]), 32'd1);
        txn(2, 1'b0, 32'h0C, 32'h0, 4'h0, rd, er, cyc);
        chk("mid_ld_0c", 2, rd, 32'h0);
        txn(2, 1'b0, 32'h14, 32'h0, 4'h0, rd, er, cyc);
        chk("mid_ld_14", 2, rd, 32'h0);

        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
